rep_upload_arb: RTL and testbench

- Two-source packet arbiter in front of the single reply FIFO of a ring node.
- Source 0 is the data-cache reply uploader (dc). Source 1 is the memory reply uploader (mem). Both emit 16-bit flits with 2-bit ctrl.
- Grants one source at a time, round-robin at packet granularity.
- Holds the grant until that source's tail flit is accepted, so flits of different packets never interleave in the reply FIFO.

---
 rtl/rep_upload_arb.sv | 139 +++++++++++++
 tb/tb_rep_upload_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_upload_arb.sv
// rtl/rep_upload_arb.sv - two-source packet arbiter feeding a ring node reply FIFO
//
// Purpose:
//   Packet-granular round-robin arbiter between the data-cache reply uploader
//   (source 0, dc) and the memory reply uploader (source 1, mem). Once a source
//   is granted it keeps the reply FIFO until its tail flit (ctrl 11) is
//   accepted, or until MAX_FLITS flits have moved without a tail, in which case
//   the grant is force-released and err_overlen is latched.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   dc_flit_in/v_dc_flit_in/dc_ctrl_in     dc uploader flit, valid, ctrl
//   dc_rdy                        dc flit accepted this cycle
//   mem_flit_in/v_mem_flit_in/mem_ctrl_in  mem uploader flit, valid, ctrl
//   mem_rdy                       mem flit accepted this cycle
//   rep_fifo_rdy                  reply FIFO can take a flit
//   rep_flit_out/v_rep_flit_out/rep_ctrl_out  flit, valid, ctrl to reply FIFO
//   rep_arb_state                 00 IDLE, 01 GNT_DC, 10 GNT_MEM
//   err_overlen                   sticky: a packet reached MAX_FLITS with no tail

module rep_upload_arb #(
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dc_flit_in,
    input  logic        v_dc_flit_in,
    input  logic [1:0]  dc_ctrl_in,
    output logic        dc_rdy,
    input  logic [15:0] mem_flit_in,
    input  logic        v_mem_flit_in,
    input  logic [1:0]  mem_ctrl_in,
    output logic        mem_rdy,
    input  logic        rep_fifo_rdy,
    output logic [15:0] rep_flit_out,
    output logic        v_rep_flit_out,
    output logic [1:0]  rep_ctrl_out,
    output logic [1:0]  rep_arb_state,
    output logic        err_overlen
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_DC  = 2'b01,
        ST_GNT_MEM = 2'b10
    } state_t;

    localparam logic [1:0]       CTRL_TAIL = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_FLITS);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;     // 0: dc wins a tie, 1: mem wins a tie
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             xfer;
    logic [1:0]       gnt_ctrl;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        dc_rdy         = 1'b0;
        mem_rdy        = 1'b0;
        rep_flit_out   = 16'h0000;
        rep_ctrl_out   = 2'b00;
        v_rep_flit_out = 1'b0;
        xfer           = 1'b0;
        gnt_ctrl       = 2'b00;
        cnt_inc        = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                // Grant takes effect next cycle; nothing moves while idle.
                if (v_dc_flit_in && v_mem_flit_in) begin
                    state_d = ptr_q ? ST_GNT_MEM : ST_GNT_DC;
                end else if (v_dc_flit_in) begin
                    state_d = ST_GNT_DC;
                end else if (v_mem_flit_in) begin
                    state_d = ST_GNT_MEM;
                end
            end
            ST_GNT_DC: begin
                rep_flit_out   = dc_flit_in;
                rep_ctrl_out   = dc_ctrl_in;
                v_rep_flit_out = v_dc_flit_in;
                dc_rdy         = rep_fifo_rdy;
                gnt_ctrl       = dc_ctrl_in;
                xfer           = v_dc_flit_in & rep_fifo_rdy;
            end
            ST_GNT_MEM: begin
                rep_flit_out   = mem_flit_in;
                rep_ctrl_out   = mem_ctrl_in;
                v_rep_flit_out = v_mem_flit_in;
                mem_rdy        = rep_fifo_rdy;
                gnt_ctrl       = mem_ctrl_in;
                xfer           = v_mem_flit_in & rep_fifo_rdy;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            if (gnt_ctrl == CTRL_TAIL || cnt_inc == CNT_MAX) begin
                // Release: tail seen, or packet ran out of budget without one.
                state_d = ST_IDLE;
                cnt_d   = '0;
                ptr_d   = (state_q == ST_GNT_DC);
                if (gnt_ctrl != CTRL_TAIL) begin
                    err_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign rep_arb_state = state_q;
    assign err_overlen   = err_q;

endmodule

// File: tb/tb_rep_upload_arb.sv
// tb/tb_rep_upload_arb.sv - self-checking bench for rep_upload_arb

module tb_rep_upload_arb;

    localparam int MAXF = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dc_flit_in, mem_flit_in, rep_flit_out;
    logic        v_dc_flit_in, v_mem_flit_in, v_rep_flit_out;
    logic [1:0]  dc_ctrl_in, mem_ctrl_in, rep_ctrl_out, rep_arb_state;
    logic        dc_rdy, mem_rdy, rep_fifo_rdy, err_overlen;

    always #5 clk = ~clk;

    rep_upload_arb #(.MAX_FLITS(MAXF), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dc_flit_in(dc_flit_in), .v_dc_flit_in(v_dc_flit_in), .dc_ctrl_in(dc_ctrl_in), .dc_rdy(dc_rdy),
        .mem_flit_in(mem_flit_in), .v_mem_flit_in(v_mem_flit_in), .mem_ctrl_in(mem_ctrl_in), .mem_rdy(mem_rdy),
        .rep_fifo_rdy(rep_fifo_rdy), .rep_flit_out(rep_flit_out), .v_rep_flit_out(v_rep_flit_out),
        .rep_ctrl_out(rep_ctrl_out), .rep_arb_state(rep_arb_state), .err_overlen(err_overlen)
    );

    // Pending packets per source as {ctrl, flit}; a flit leaves when accepted.
    logic [17:0] dc_q[$];
    logic [17:0] mem_q[$];
    bit          rdy_pat[$];
    int          vprob, rprob;

    // Reference model: owner of the FIFO (-1 nobody), tie winner, flits moved.
    int m_g, m_ptr, m_cnt;
    bit m_err;
    int cyc;

    logic [15:0] out_flit[$];
    int          out_src[$];
    int          out_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic push_pkt(input int src, input int len, input logic [15:0] base);
        logic [1:0] c;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) c = 2'b11;
            else if (i == 0)  c = 2'b01;
            else              c = 2'b10;
            if (src == 0) dc_q.push_back({c, base + 16'(i)});
            else          mem_q.push_back({c, base + 16'(i)});
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        v_dc_flit_in = 1'b0; v_mem_flit_in = 1'b0;
        dc_flit_in = 16'($urandom); mem_flit_in = 16'($urandom);
        dc_ctrl_in = 2'($urandom); mem_ctrl_in = 2'($urandom);
        rep_fifo_rdy = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
        m_g = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        dc_q.delete(); mem_q.delete(); rdy_pat.delete();
        out_flit.delete(); out_src.delete(); out_cyc.delete();
        cyc = 0;
    endtask

    task automatic run_cycles(input int n);
        logic [23:0] exp_v, act_v;
        bit vd, vm, fr, xv;
        logic [1:0] c;
        int ng, nptr, ncnt;
        bit nerr;
        for (int i = 0; i < n; i++) begin
            vd = (dc_q.size() > 0) && ($urandom_range(99) < vprob);
            vm = (mem_q.size() > 0) && ($urandom_range(99) < vprob);
            v_dc_flit_in  = vd;
            v_mem_flit_in = vm;
            {dc_ctrl_in, dc_flit_in}   = vd ? dc_q[0]  : 18'($urandom);
            {mem_ctrl_in, mem_flit_in} = vm ? mem_q[0] : 18'($urandom);
            fr = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : ($urandom_range(99) < rprob);
            rep_fifo_rdy = fr;
            #4;
            if (m_g == 0)      exp_v = {fr, 1'b0, vd, dc_flit_in, dc_ctrl_in, 2'b01, m_err};
            else if (m_g == 1) exp_v = {1'b0, fr, vm, mem_flit_in, mem_ctrl_in, 2'b10, m_err};
            else               exp_v = {23'd0, m_err};
            act_v = {dc_rdy, mem_rdy, v_rep_flit_out, rep_flit_out, rep_ctrl_out, rep_arb_state, err_overlen};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs cyc=%0d got rdy=%b%b v=%b flit=%h ctrl=%b st=%b err=%b expected %h (packed)",
                         cyc, dc_rdy, mem_rdy, v_rep_flit_out, rep_flit_out, rep_ctrl_out, rep_arb_state, err_overlen, exp_v);
            end
            ng = m_g; nptr = m_ptr; ncnt = m_cnt; nerr = m_err;
            if (m_g < 0) begin
                if (vd && vm)  ng = m_ptr;
                else if (vd)   ng = 0;
                else if (vm)   ng = 1;
            end else begin
                xv = (m_g == 0) ? vd : vm;
                if (xv && fr) begin
                    if (m_g == 0) begin c = dc_q[0][17:16];  out_flit.push_back(dc_q[0][15:0]);  void'(dc_q.pop_front()); end
                    else          begin c = mem_q[0][17:16]; out_flit.push_back(mem_q[0][15:0]); void'(mem_q.pop_front()); end
                    out_src.push_back(m_g);
                    out_cyc.push_back(cyc);
                    ncnt = m_cnt + 1;
                    if (c == 2'b11 || ncnt == MAXF) begin
                        if (c != 2'b11) nerr = 1'b1;
                        ng = -1; ncnt = 0; nptr = 1 - m_g;
                    end
                end
            end
            @(posedge clk); #1;
            m_g = ng; m_ptr = nptr; m_cnt = ncnt; m_err = nerr;
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        v_dc_flit_in = 1'b1; v_mem_flit_in = 1'b1; rep_fifo_rdy = 1'b1;
        #4;
        n_checks++;
        if ({dc_rdy, mem_rdy, v_rep_flit_out, rep_flit_out, rep_ctrl_out, rep_arb_state, err_overlen} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got st=%b v=%b flit=%h err=%b expected all zero",
                     rep_arb_state, v_rep_flit_out, rep_flit_out, err_overlen);
        end
        v_dc_flit_in = 1'b0; v_mem_flit_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_dc();
        do_reset();
        vprob = 100; rprob = 100;
        dc_q.push_back({2'b11, 16'h2001});
        run_cycles(3);
        n_checks++;
        if (out_flit.size() != 1 || out_flit[0] !== 16'h2001 || out_cyc[0] != 1) begin
            n_fail++;
            $display("FAIL single_dc got n=%0d flit=%h cyc=%0d expected 1 flit 2001 at cycle 1",
                     out_flit.size(), out_flit.size() ? out_flit[0] : 16'hx, out_cyc.size() ? out_cyc[0] : -1);
        end
        // Pointer now favours mem: a simultaneous pair must go to mem.
        dc_q.push_back({2'b11, 16'h2002});
        mem_q.push_back({2'b11, 16'h3002});
        run_cycles(3);
        n_checks++;
        if (out_src.size() < 2 || out_src[1] != 1) begin
            n_fail++;
            $display("FAIL ptr_after_dc got src=%0d expected 1", out_src.size() > 1 ? out_src[1] : -1);
        end
    endtask

    task automatic test_contention();
        logic [15:0] exp_f[6] = '{16'hc0de, 16'hc1de, 16'hc2de, 16'h0401, 16'h0402, 16'h0403};
        do_reset();
        vprob = 100; rprob = 100;
        dc_q.push_back({2'b01, 16'hc0de}); dc_q.push_back({2'b10, 16'hc1de}); dc_q.push_back({2'b11, 16'hc2de});
        push_pkt(1, 3, 16'h0401);
        run_cycles(10);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= out_flit.size() || out_flit[i] !== exp_f[i]) begin
                n_fail++;
                $display("FAIL contention_flit%0d got %h expected %h", i, i < out_flit.size() ? out_flit[i] : 16'hx, exp_f[i]);
            end
        end
        n_checks++;
        if (out_cyc.size() < 6 || out_cyc[0] != 1 || out_cyc[3] - out_cyc[2] != 2) begin
            n_fail++;
            $display("FAIL contention_timing got first=%0d gap=%0d expected 1 and 2",
                     out_cyc.size() ? out_cyc[0] : -1, out_cyc.size() >= 4 ? out_cyc[3] - out_cyc[2] : -1);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        vprob = 100; rprob = 100;
        for (int i = 0; i < 4; i++) begin
            dc_q.push_back({2'b11, 16'h1000 + 16'(i)});
            mem_q.push_back({2'b11, 16'h2000 + 16'(i)});
        end
        run_cycles(18);
        n_checks++;
        if (out_src.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count got %0d expected 8", out_src.size());
        end
        for (int i = 0; i < out_src.size(); i++) begin
            n_checks++;
            if (out_src[i] != (i % 2) || (i > 0 && out_cyc[i] - out_cyc[i-1] != 2)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got src=%0d gap=%0d expected src=%0d gap=2",
                         i, out_src[i], i > 0 ? out_cyc[i] - out_cyc[i-1] : 2, i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        bit pat[16] = '{1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
        do_reset();
        vprob = 100; rprob = 100;
        push_pkt(0, 9, 16'h5a00);
        push_pkt(1, 1, 16'h7700);
        foreach (pat[i]) rdy_pat.push_back(pat[i]);
        run_cycles(20);
        n_checks++;
        if (out_flit.size() != 10 || out_cyc[8] != 15 || out_cyc[9] != 17 || out_src[9] != 1) begin
            n_fail++;
            $display("FAIL backpressure got n=%0d tail_cyc=%0d mem_cyc=%0d expected 10 15 17",
                     out_flit.size(), out_cyc.size() > 8 ? out_cyc[8] : -1, out_cyc.size() > 9 ? out_cyc[9] : -1);
        end
        for (int i = 0; i < 9 && i < out_flit.size(); i++) begin
            n_checks++;
            if (out_flit[i] !== 16'h5a00 + 16'(i)) begin
                n_fail++;
                $display("FAIL bp_order%0d got %h expected %h", i, out_flit[i], 16'h5a00 + 16'(i));
            end
        end
    endtask

    task automatic test_overlength();
        do_reset();
        vprob = 100; rprob = 100;
        for (int i = 0; i < MAXF; i++) dc_q.push_back({2'b10, 16'h0b00 + 16'(i)});
        push_pkt(0, 2, 16'h0c00);
        push_pkt(1, 1, 16'h0d00);
        run_cycles(24);
        n_checks++;
        if (err_overlen !== 1'b1 || out_flit.size() != 14 || out_src[11] != 1) begin
            n_fail++;
            $display("FAIL overlen got err=%b n=%0d expected err=1 n=14 with mem after release",
                     err_overlen, out_flit.size());
        end
        do_reset();
        #4;
        n_checks++;
        if (err_overlen !== 1'b0) begin
            n_fail++;
            $display("FAIL overlen_clear got %b expected 0", err_overlen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        vprob = 100; rprob = 100;
        dc_q.push_back({2'b11, 16'h0e00});
        run_cycles(3);                      // pointer now mem
        push_pkt(1, 9, 16'h0f00);
        run_cycles(5);                      // grant + 4 flits
        do_reset();
        #4;
        n_checks++;
        if ({dc_rdy, mem_rdy, v_rep_flit_out, rep_flit_out, rep_ctrl_out, rep_arb_state, err_overlen} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got st=%b v=%b flit=%h expected zero", rep_arb_state, v_rep_flit_out, rep_flit_out);
        end
        @(posedge clk); #1;
        push_pkt(0, 2, 16'h1100);
        push_pkt(1, 2, 16'h2200);
        run_cycles(8);
        n_checks++;
        if (out_src.size() != 4 || out_src[0] != 0 || out_src[2] != 1) begin
            n_fail++;
            $display("FAIL reset_mid_ptr got first_src=%0d n=%0d expected 0 and 4",
                     out_src.size() ? out_src[0] : -1, out_src.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 3; seg++) begin
            vprob = 50 + 20 * seg; rprob = 90 - 25 * seg;
            for (int p = 0; p < 25; p++) begin
                push_pkt(0, $urandom_range(1, 13), 16'($urandom));
                push_pkt(1, $urandom_range(1, 13), 16'($urandom));
            end
            run_cycles(600);
        end
    endtask

    initial begin
        rst = 1'b1;
        v_dc_flit_in = 1'b0; v_mem_flit_in = 1'b0; rep_fifo_rdy = 1'b0;
        dc_flit_in = '0; mem_flit_in = '0; dc_ctrl_in = '0; mem_ctrl_in = '0;
        vprob = 100; rprob = 100;
        @(posedge clk); #1;
        test_reset();
        test_single_dc();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_overlength();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
